max6675_reader: RTL

SPI-style reader for the MAX6675 thermocouple converter: waits out the conversion time and drives chip-select and serial clock. It then shifts in the 16-bit frame and publishes the temperature in whole degrees Celsius on a 12-bit bus, with a one-cycle valid strobe. It is the producer of the temperature bus that the seven-segment display path consumes, and sits between the board-level SO/SCK/CS pins and the display logic.

---
 rtl/max6675_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/max6675_reader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/max6675_pkg.sv
// Shared types and frame layout for the MAX6675 thermocouple reader.
// Bit positions index the 16-bit frame as it leaves the converter, MSB first.
package max6675_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int DUMMY_BIT  = 15;
  localparam int TEMP_MSB   = 14;
  localparam int TEMP_LSB   = 3;
  localparam int OPEN_BIT   = 2;
  localparam int ID_BIT     = 1;

  // Bit 0 (tristate) is never captured, so frames are carried as [15:1].
  function automatic logic frame_bad(input logic [FRAME_BITS-1:1] f);
    return f[DUMMY_BIT] | f[ID_BIT];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/max6675_reader.sv
// Periodic MAX6675 reader: waits out the conversion, clocks in one frame,
// and publishes whole-degree temperature with a one-cycle valid strobe.
module max6675_reader
  import max6675_pkg::*;
#(
  parameter int SCK_HALF_CYCLES = 25,
  parameter int CONV_CYCLES     = 11_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        so,
  output logic        cs_n,
  output logic        sck,
  output logic [11:0] temperature,
  output logic [1:0]  frac,
  output logic        open_tc,
  output logic        frame_err,
  output logic        valid,
  output logic [1:0]  debug_state
);

  localparam int CNT_MAX = (CONV_CYCLES > SCK_HALF_CYCLES) ? CONV_CYCLES : SCK_HALF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCK_HALF_CYCLES - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [3:0]              bit_cnt;
  logic [FRAME_BITS-1:1]   frame_q;
  logic                    so_s;

  sync_2ff u_so_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (so),
    .q     (so_s)
  );

  assign debug_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT;
      cnt         <= '0;
      bit_cnt     <= '0;
      frame_q     <= '0;
      cs_n        <= 1'b1;
      sck         <= 1'b0;
      temperature <= '0;
      frac        <= '0;
      open_tc     <= 1'b0;
      frame_err   <= 1'b0;
      valid       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        WAIT: begin
          cs_n <= 1'b1;
          sck  <= 1'b0;
          if (en) begin
            if (cnt == CONV_LAST) begin
              cnt   <= '0;
              cs_n  <= 1'b0;
              state <= SETUP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        // tCSS; the closing edge raises sck and takes the first (MSB) sample.
        SETUP: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            sck     <= 1'b1;
            bit_cnt <= '0;
            frame_q <= {frame_q[FRAME_BITS-2:1], so_s};
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (sck) begin
              sck <= 1'b0;
            end else if (bit_cnt == 4'(FRAME_BITS - 1)) begin
              cs_n  <= 1'b1;
              state <= DONE;
            end else begin
              sck     <= 1'b1;
              bit_cnt <= bit_cnt + 1'b1;
              // The last sample is the tristate bit, which is dropped.
              if (bit_cnt != 4'(FRAME_BITS - 2))
                frame_q <= {frame_q[FRAME_BITS-2:1], so_s};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          frame_err <= frame_bad(frame_q);
          open_tc   <= frame_q[OPEN_BIT];
          if (!frame_bad(frame_q) && !frame_q[OPEN_BIT]) begin
            temperature <= {2'b00, frame_q[TEMP_MSB:TEMP_LSB+2]};
            frac        <= frame_q[TEMP_LSB+1:TEMP_LSB];
          end
          valid <= 1'b1;
          cs_n  <= 1'b1;
          sck   <= 1'b0;
          cnt   <= '0;
          state <= WAIT;
        end

        default: begin
          cs_n  <= 1'b1;
          sck   <= 1'b0;
          cnt   <= '0;
          state <= WAIT;
        end
      endcase
    end
  end

endmodule
